// File: rtl/clk_div_bank_pkg.sv
// clk_div_pkg -- shared types and defaults for the clk_div_bank divider family.
//
// Contents:
//   state_t          : global startup FSM states (ST_WAIT, ST_RUN)
//   CLK_DIV_*        : default constants (counter width, startup delay,
//                      reset half-period and reset phase)
//   chan_cfg_t       : one channel's {half, phase} configuration word
//   sanitize_cfg()   : forces a config word into its legal range
package clk_div_pkg;

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // The field width of chan_cfg_t; the bank's CNT_W must not exceed it.
   localparam int CLK_DIV_CNT_W     = 20;
   localparam int CLK_DIV_STARTUP   = 10;
   localparam int CLK_DIV_DEF_HALF  = 51;
   localparam int CLK_DIV_DEF_PHASE = 0;

   typedef struct packed {
      logic [CLK_DIV_CNT_W-1:0] half;
      logic [CLK_DIV_CNT_W-1:0] phase;
   } chan_cfg_t;

   // A zero half-period would never match count == H-1, so it becomes 1.
   // A phase at or beyond the half-period would overshoot the terminal
   // count, so it becomes 0.
   function automatic chan_cfg_t sanitize_cfg(input chan_cfg_t raw);
      chan_cfg_t c;
      c.half  = (raw.half == '0) ? CLK_DIV_CNT_W'(1) : raw.half;
      c.phase = (raw.phase >= c.half) ? '0 : raw.phase;
      return c;
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if -- valid/ready configuration port of clk_div_bank.
//
// Signals:
//   cfg_valid  : request from the master
//   cfg_ready  : accept from the bank; a write happens on valid & ready
//   cfg_ch     : target channel (values >= N_CH are accepted and dropped)
//   cfg_half   : new half-period in input clock cycles
//   cfg_phase  : new start count
// Modports: master drives the request, slave (the bank) drives ready.
interface clk_div_bank_if #(
   parameter int N_CH  = 3,
   parameter int CNT_W = 20
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_half;
   logic [CNT_W-1:0] cfg_phase;

   modport master (
      output cfg_valid,
      output cfg_ch,
      output cfg_half,
      output cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_ch,
      input  cfg_half,
      input  cfg_phase,
      output cfg_ready
   );

endinterface

// File: rtl/clk_div_bank_chan.sv
// clk_div_chan -- one glitch-free divided-clock channel of clk_div_bank.
//
// Ports:
//   clk, rst   : input clock, synchronous active-high reset
//   run_i      : global startup FSM is in ST_RUN
//   en_i       : this channel's run enable
//   wr_i       : accepted configuration write for this channel
//   wr_cfg_i   : already-sanitized {half, phase} of that write
//   pending_o  : a write is held waiting to be applied
//   clk_o      : divided clock (registered)
//   rise_o     : strobe coinciding with clk_o going 0->1
//   fall_o     : strobe coinciding with clk_o going 1->0
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W     = CLK_DIV_CNT_W,
   parameter int DEF_HALF  = CLK_DIV_DEF_HALF,
   parameter int DEF_PHASE = CLK_DIV_DEF_PHASE
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      run_i,
   input  logic      en_i,
   input  logic      wr_i,
   input  chan_cfg_t wr_cfg_i,
   output logic      pending_o,
   output logic      clk_o,
   output logic      rise_o,
   output logic      fall_o
);

   localparam int RST_HALF  = (DEF_HALF == 0) ? 1 : DEF_HALF;
   localparam int RST_PHASE = (DEF_PHASE >= RST_HALF) ? 0 : DEF_PHASE;

   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] phase_q, phase_d;
   logic [CNT_W-1:0] count_q, count_d;
   chan_cfg_t        pend_cfg_q, pend_cfg_d;
   logic             pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             started_q, started_d;

   logic             go;
   logic             run_now;
   logic             restart;
   logic             at_end;
   logic [CNT_W-1:0] pend_half;
   logic [CNT_W-1:0] pend_phase;

   // A channel that has been told to stop while high keeps running until
   // its fall toggle, so the high phase is never cut short.
   assign go         = run_i & en_i;
   assign run_now    = go | clk_q;
   assign restart    = run_now & ~started_q;
   assign at_end     = (count_q == (half_q - CNT_W'(1)));
   assign pend_half  = CNT_W'(pend_cfg_q.half);
   assign pend_phase = CNT_W'(pend_cfg_q.phase);

   always_comb begin
      half_d     = half_q;
      phase_d    = phase_q;
      count_d    = count_q;
      pend_d     = pend_q;
      pend_cfg_d = pend_cfg_q;
      clk_d      = clk_q;
      rise_d     = 1'b0;
      fall_d     = 1'b0;
      started_d  = run_now;

      if (!run_now) begin
         // Parked low: count sits on the start phase so that a restart
         // begins counting from P in its very first running cycle.
         clk_d = 1'b0;
         if (pend_q) begin
            half_d  = pend_half;
            phase_d = pend_phase;
            count_d = pend_phase;
            pend_d  = 1'b0;
         end else begin
            count_d = phase_q;
         end
      end else if (restart && pend_q) begin
         // A held update takes priority over restarting with stale values.
         half_d  = pend_half;
         phase_d = pend_phase;
         count_d = pend_phase;
         pend_d  = 1'b0;
      end else if (at_end) begin
         clk_d = ~clk_q;
         if (clk_q) begin
            fall_d = 1'b1;
            if (pend_q) begin
               half_d  = pend_half;
               phase_d = pend_phase;
               count_d = pend_phase;
               pend_d  = 1'b0;
            end else if (go) begin
               count_d = '0;
            end else begin
               count_d = phase_q;
            end
         end else begin
            rise_d  = 1'b1;
            count_d = '0;
         end
      end else begin
         count_d = count_q + CNT_W'(1);
      end

      // Writes only arrive while nothing is pending, so this never races
      // with the clear above.
      if (wr_i) begin
         pend_d     = 1'b1;
         pend_cfg_d = wr_cfg_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         half_q     <= CNT_W'(RST_HALF);
         phase_q    <= CNT_W'(RST_PHASE);
         count_q    <= CNT_W'(RST_PHASE);
         pend_cfg_q <= '0;
         pend_q     <= 1'b0;
         clk_q      <= 1'b0;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         started_q  <= 1'b0;
      end else begin
         half_q     <= half_d;
         phase_q    <= phase_d;
         count_q    <= count_d;
         pend_cfg_q <= pend_cfg_d;
         pend_q     <= pend_d;
         clk_q      <= clk_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         started_q  <= started_d;
      end
   end

   assign pending_o = pend_q;
   assign clk_o     = clk_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank -- multi-channel clock divider with a startup sync flag.
//
// Ports:
//   CLKIN     : sole clock, rising edge
//   Reset     : synchronous, active-high
//   ch_en     : per-channel run enable
//   cfg       : valid/ready configuration port (slave side)
//   SYN1      : sticky flag, high once the startup delay has elapsed
//   clk_out   : divided clocks
//   clk_rise  : one-cycle strobes on each clk_out 0->1
//   clk_fall  : one-cycle strobes on each clk_out 1->0
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int CNT_W     = CLK_DIV_CNT_W,
   parameter int STARTUP   = CLK_DIV_STARTUP,
   parameter int DEF_HALF  = CLK_DIV_DEF_HALF,
   parameter int DEF_PHASE = CLK_DIV_DEF_PHASE
) (
   input  logic                CLKIN,
   input  logic                Reset,
   input  logic [N_CH-1:0]     ch_en,
   clk_div_bank_if.slave       cfg,
   output logic                SYN1,
   output logic [N_CH-1:0]     clk_out,
   output logic [N_CH-1:0]     clk_rise,
   output logic [N_CH-1:0]     clk_fall
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] start_cnt_q, start_cnt_d;

   logic [N_CH-1:0]        pending;
   logic [(1<<CH_W)-1:0]   pending_ext;
   logic [N_CH-1:0]        wr_sel;
   logic                   ch_in_range;
   logic                   cfg_fire;
   chan_cfg_t              cfg_raw;
   chan_cfg_t              cfg_clean;

   always_comb begin
      state_d     = state_q;
      start_cnt_d = start_cnt_q;
      case (state_q)
         ST_WAIT: begin
            if (start_cnt_q == CNT_W'(STARTUP - 1)) begin
               state_d = ST_RUN;
            end else begin
               start_cnt_d = start_cnt_q + CNT_W'(1);
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge CLKIN) begin
      if (Reset) begin
         state_q     <= ST_WAIT;
         start_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         start_cnt_q <= start_cnt_d;
      end
   end

   assign SYN1 = (state_q == ST_RUN);

   // The pending vector is widened to a power of two so that any cfg_ch
   // value can index it; out-of-range channels always read as ready.
   always_comb begin
      pending_ext              = '0;
      pending_ext[N_CH-1:0]    = pending;
      ch_in_range              = (int'(cfg.cfg_ch) < N_CH);
      cfg.cfg_ready            = ch_in_range ? ~pending_ext[cfg.cfg_ch] : 1'b1;
      cfg_fire                 = cfg.cfg_valid & cfg.cfg_ready;
      wr_sel                   = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_fire && (int'(cfg.cfg_ch) == i)) begin
            wr_sel[i] = 1'b1;
         end
      end
      cfg_raw.half  = CLK_DIV_CNT_W'(cfg.cfg_half);
      cfg_raw.phase = CLK_DIV_CNT_W'(cfg.cfg_phase);
      cfg_clean     = sanitize_cfg(cfg_raw);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      clk_div_chan #(
         .CNT_W     (CNT_W),
         .DEF_HALF  (DEF_HALF),
         .DEF_PHASE (DEF_PHASE)
      ) u_chan (
         .clk       (CLKIN),
         .rst       (Reset),
         .run_i     (SYN1),
         .en_i      (ch_en[i]),
         .wr_i      (wr_sel[i]),
         .wr_cfg_i  (cfg_clean),
         .pending_o (pending[i]),
         .clk_o     (clk_out[i]),
         .rise_o    (clk_rise[i]),
         .fall_o    (clk_fall[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank -- directed self-checking bench for clk_div_bank.
// Cycle numbers below count from the first cycle with Reset low.
module tb_clk_div_bank;

   logic       CLKIN;
   logic       Reset;
   logic [2:0] ch_en;
   logic       SYN1;
   logic [2:0] clk_out;
   logic [2:0] clk_rise;
   logic [2:0] clk_fall;

   int cyc;
   int checks;
   int errors;

   clk_div_bank_if #(.N_CH(3), .CNT_W(20)) cfg_bus ();

   clk_div_bank #(
      .N_CH      (3),
      .CNT_W     (20),
      .STARTUP   (10),
      .DEF_HALF  (51),
      .DEF_PHASE (0)
   ) dut (
      .CLKIN    (CLKIN),
      .Reset    (Reset),
      .ch_en    (ch_en),
      .cfg      (cfg_bus),
      .SYN1     (SYN1),
      .clk_out  (clk_out),
      .clk_rise (clk_rise),
      .clk_fall (clk_fall)
   );

   initial CLKIN = 1'b0;
   always #5 CLKIN = ~CLKIN;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] ch,
                                input logic [19:0] h, input logic [19:0] p);
      cfg_bus.cfg_valid = v;
      cfg_bus.cfg_ch    = ch;
      cfg_bus.cfg_half  = h;
      cfg_bus.cfg_phase = p;
      #1;
   endtask

   task automatic advanceTo(input int target);
      while (cyc < target) begin
         @(posedge CLKIN);
         #1;
         cyc++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      Reset  = 1'b1;
      ch_en  = 3'b111;
      applyStimulus(1'b0, 2'd0, 20'd0, 20'd0);

      repeat (3) @(posedge CLKIN);
      #1;
      checkOutput("rst_syn1",  32'(SYN1), 32'h0);
      checkOutput("rst_clk",   32'(clk_out), 32'h0);
      checkOutput("rst_ready", 32'(cfg_bus.cfg_ready), 32'h1);

      // Startup and default waveform
      Reset = 1'b0;
      cyc   = 0;
      checkOutput("c0_syn1", 32'(SYN1), 32'h0);
      checkOutput("c0_rise", 32'(clk_rise), 32'h0);
      checkOutput("c0_fall", 32'(clk_fall), 32'h0);
      advanceTo(9);
      checkOutput("c9_syn1", 32'(SYN1), 32'h0);
      advanceTo(10);
      checkOutput("c10_syn1", 32'(SYN1), 32'h1);
      checkOutput("c10_clk",  32'(clk_out), 32'h0);
      advanceTo(60);
      checkOutput("c60_clk", 32'(clk_out), 32'h0);
      advanceTo(61);
      checkOutput("c61_clk",  32'(clk_out), 32'h7);
      checkOutput("c61_rise", 32'(clk_rise), 32'h7);
      checkOutput("c61_fall", 32'(clk_fall), 32'h0);
      advanceTo(62);
      checkOutput("c62_rise", 32'(clk_rise), 32'h0);
      checkOutput("c62_clk",  32'(clk_out), 32'h7);
      advanceTo(111);
      checkOutput("c111_clk", 32'(clk_out), 32'h7);
      advanceTo(112);
      checkOutput("c112_clk",  32'(clk_out), 32'h0);
      checkOutput("c112_fall", 32'(clk_fall), 32'h7);

      // Mid-run write of ch1 {4,2}, then a refused second write
      advanceTo(120);
      applyStimulus(1'b1, 2'd1, 20'd4, 20'd2);
      checkOutput("c120_ready_ch1", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(121);
      applyStimulus(1'b1, 2'd1, 20'd9, 20'd1);
      checkOutput("c121_ready_ch1", 32'(cfg_bus.cfg_ready), 32'h0);
      advanceTo(122);
      applyStimulus(1'b0, 2'd1, 20'd0, 20'd0);

      // ch2 still writable while ch1 waits; ch3 does not exist
      advanceTo(130);
      applyStimulus(1'b1, 2'd2, 20'd51, 20'd0);
      checkOutput("c130_ready_ch2", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(131);
      applyStimulus(1'b1, 2'd3, 20'd9, 20'd9);
      checkOutput("c131_ready_ch3", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(132);
      applyStimulus(1'b0, 2'd2, 20'd0, 20'd0);
      checkOutput("c132_ready_ch2", 32'(cfg_bus.cfg_ready), 32'h0);

      advanceTo(163);
      checkOutput("c163_clk",  32'(clk_out), 32'h7);
      checkOutput("c163_rise", 32'(clk_rise), 32'h7);
      advanceTo(213);
      checkOutput("c213_clk", 32'(clk_out), 32'h7);
      advanceTo(214);
      checkOutput("c214_clk",  32'(clk_out), 32'h0);
      checkOutput("c214_fall", 32'(clk_fall), 32'h7);
      applyStimulus(1'b0, 2'd1, 20'd0, 20'd0);
      checkOutput("c214_ready_ch1", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(215);
      checkOutput("c215_clk", 32'(clk_out), 32'h0);
      advanceTo(216);
      checkOutput("c216_clk",  32'(clk_out), 32'h2);
      checkOutput("c216_rise", 32'(clk_rise), 32'h2);
      advanceTo(219);
      checkOutput("c219_clk", 32'(clk_out), 32'h2);
      advanceTo(220);
      checkOutput("c220_clk",  32'(clk_out), 32'h0);
      checkOutput("c220_fall", 32'(clk_fall), 32'h2);
      advanceTo(224);
      checkOutput("c224_clk", 32'(clk_out), 32'h2);
      advanceTo(265);
      checkOutput("c265_clk",  32'(clk_out), 32'h7);
      checkOutput("c265_rise", 32'(clk_rise), 32'h5);

      // Disable ch0 during its high phase, then re-enable
      advanceTo(280);
      ch_en = 3'b110;
      advanceTo(315);
      checkOutput("c315_ch0", 32'(clk_out[0]), 32'h1);
      advanceTo(316);
      checkOutput("c316_ch0",      32'(clk_out[0]), 32'h0);
      checkOutput("c316_ch0_fall", 32'(clk_fall[0]), 32'h1);
      advanceTo(367);
      checkOutput("c367_ch0",      32'(clk_out[0]), 32'h0);
      checkOutput("c367_ch0_rise", 32'(clk_rise[0]), 32'h0);
      checkOutput("c367_ch2",      32'(clk_out[2]), 32'h1);
      advanceTo(400);
      ch_en = 3'b111;
      advanceTo(450);
      checkOutput("c450_ch0", 32'(clk_out[0]), 32'h0);
      advanceTo(451);
      checkOutput("c451_ch0",      32'(clk_out[0]), 32'h1);
      checkOutput("c451_ch0_rise", 32'(clk_rise[0]), 32'h1);

      // Sanitizing: ch2 {0,7} -> {1,0}; ch0 {6,9} -> {6,0}
      advanceTo(460);
      applyStimulus(1'b1, 2'd2, 20'd0, 20'd7);
      checkOutput("c460_ready_ch2", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(461);
      applyStimulus(1'b0, 2'd0, 20'd0, 20'd0);
      advanceTo(470);
      applyStimulus(1'b1, 2'd0, 20'd6, 20'd9);
      checkOutput("c470_ready_ch0", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(471);
      applyStimulus(1'b0, 2'd0, 20'd0, 20'd0);
      advanceTo(502);
      checkOutput("c502_ch0",      32'(clk_out[0]), 32'h0);
      checkOutput("c502_ch0_fall", 32'(clk_fall[0]), 32'h1);
      advanceTo(507);
      checkOutput("c507_ch0", 32'(clk_out[0]), 32'h0);
      advanceTo(508);
      checkOutput("c508_ch0",      32'(clk_out[0]), 32'h1);
      checkOutput("c508_ch0_rise", 32'(clk_rise[0]), 32'h1);
      advanceTo(513);
      checkOutput("c513_ch0", 32'(clk_out[0]), 32'h1);
      advanceTo(514);
      checkOutput("c514_ch0", 32'(clk_out[0]), 32'h0);
      advanceTo(519);
      checkOutput("c519_ch2", 32'(clk_out[2]), 32'h1);
      advanceTo(520);
      checkOutput("c520_ch2",      32'(clk_out[2]), 32'h0);
      checkOutput("c520_ch2_fall", 32'(clk_fall[2]), 32'h1);
      advanceTo(521);
      checkOutput("c521_ch2",      32'(clk_out[2]), 32'h1);
      checkOutput("c521_ch2_rise", 32'(clk_rise[2]), 32'h1);
      advanceTo(522);
      checkOutput("c522_ch2",      32'(clk_out[2]), 32'h0);
      checkOutput("c522_ch2_fall", 32'(clk_fall[2]), 32'h1);
      advanceTo(523);
      checkOutput("c523_ch2", 32'(clk_out[2]), 32'h1);

      // Reset with a write to ch0 still pending
      advanceTo(528);
      applyStimulus(1'b1, 2'd0, 20'd10, 20'd3);
      checkOutput("c528_ready_ch0", 32'(cfg_bus.cfg_ready), 32'h1);
      advanceTo(529);
      applyStimulus(1'b0, 2'd0, 20'd0, 20'd0);
      checkOutput("c529_ready_ch0", 32'(cfg_bus.cfg_ready), 32'h0);
      advanceTo(530);
      Reset = 1'b1;
      advanceTo(531);
      checkOutput("rr_syn1",  32'(SYN1), 32'h0);
      checkOutput("rr_clk",   32'(clk_out), 32'h0);
      checkOutput("rr_rise",  32'(clk_rise), 32'h0);
      checkOutput("rr_fall",  32'(clk_fall), 32'h0);
      checkOutput("rr_ready", 32'(cfg_bus.cfg_ready), 32'h1);

      Reset = 1'b0;
      cyc   = 0;
      advanceTo(9);
      checkOutput("r9_syn1", 32'(SYN1), 32'h0);
      advanceTo(10);
      checkOutput("r10_syn1", 32'(SYN1), 32'h1);
      advanceTo(60);
      checkOutput("r60_clk", 32'(clk_out), 32'h0);
      advanceTo(61);
      checkOutput("r61_clk",  32'(clk_out), 32'h7);
      checkOutput("r61_rise", 32'(clk_rise), 32'h7);
      advanceTo(111);
      checkOutput("r111_clk", 32'(clk_out), 32'h7);
      advanceTo(112);
      checkOutput("r112_clk",  32'(clk_out), 32'h0);
      checkOutput("r112_fall", 32'(clk_fall), 32'h7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
